// File: rtl/amba_axi4_lite_types_pkg.sv
// Shared AXI4-Lite types: response codes, protection bits, master FSM states
// and the response mapping applied before a slave response is reported.
package amba_axi4_lite_types_pkg;

  typedef enum logic [1:0] {
    AXI4_RESP_OKAY   = 2'b00,
    AXI4_RESP_EXOKAY = 2'b01,
    AXI4_RESP_SLVERR = 2'b10,
    AXI4_RESP_DECERR = 2'b11
  } axi4_resp_el;

  typedef struct packed {
    logic instruction;
    logic non_secure;
    logic privileged;
  } axi4_prot_typel;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_RSP
  } axi4_lite_mst_state_e;

  // Exclusive access does not exist on AXI4-Lite, so EXOKAY is treated as an error.
  function automatic axi4_resp_el axi4_lite_map_resp(input logic [1:0] resp);
    axi4_resp_el r;
    r = axi4_resp_el'(resp);
    if (r == AXI4_RESP_EXOKAY) r = AXI4_RESP_SLVERR;
    return r;
  endfunction

endpackage

// File: rtl/amba_axi4_lite_hold_ch.sv
// One request channel holder: valid rises on load and falls the cycle after
// its own handshake; payload is captured on load and held while valid is high.
module amba_axi4_lite_hold_ch #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_payload,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] payload,
  output logic         hs_c
);

  assign hs_c = valid & ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid   <= 1'b0;
      payload <= '0;
    end else if (load) begin
      valid   <= 1'b1;
      payload <= load_payload;
    end else if (hs_c) begin
      valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/amba_axi4_lite_master.sv
// AXI4-Lite manager: takes one single-beat read/write command at a time, runs
// the AW/W/B or AR/R handshakes and returns data plus response on the rsp port.
module amba_axi4_lite_master
  import amba_axi4_lite_types_pkg::*;
#(
  parameter  int unsigned ADDR_W = 32,
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [STRB_W-1:0] cmd_wstrb,
  input  logic [2:0]        cmd_prot,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [2:0]        m_awprot,
  output logic              m_wvalid,
  input  logic              m_wready,
  output logic [DATA_W-1:0] m_wdata,
  output logic [STRB_W-1:0] m_wstrb,
  input  logic              m_bvalid,
  output logic              m_bready,
  input  logic [1:0]        m_bresp,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [2:0]        m_arprot,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp
);

  localparam int unsigned AX_W = ADDR_W + 3;
  localparam int unsigned WP_W = DATA_W + STRB_W;

  axi4_lite_mst_state_e state_q, state_d;

  logic              cmd_ready_d, bready_d, rready_d;
  logic              rsp_valid_d, rsp_write_d;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic [1:0]        rsp_resp_d;
  logic              aw_done_q, aw_done_d, w_done_q, w_done_d;

  logic              accept_c, load_wr_c, load_rd_c;
  logic              aw_hs_c, w_hs_c, ar_hs_c;
  logic [AX_W-1:0]   aw_payload, ar_payload;
  logic [WP_W-1:0]   w_payload;

  // cmd_ready is only high in IDLE, so an accept always starts from IDLE.
  assign accept_c  = cmd_valid & cmd_ready;
  assign load_wr_c = accept_c & cmd_write;
  assign load_rd_c = accept_c & ~cmd_write;

  amba_axi4_lite_hold_ch #(.W(AX_W)) u_aw (
    .clk(clk), .rst(rst), .load(load_wr_c), .load_payload({cmd_addr, cmd_prot}),
    .ready(m_awready), .valid(m_awvalid), .payload(aw_payload), .hs_c(aw_hs_c)
  );

  amba_axi4_lite_hold_ch #(.W(WP_W)) u_w (
    .clk(clk), .rst(rst), .load(load_wr_c), .load_payload({cmd_wdata, cmd_wstrb}),
    .ready(m_wready), .valid(m_wvalid), .payload(w_payload), .hs_c(w_hs_c)
  );

  amba_axi4_lite_hold_ch #(.W(AX_W)) u_ar (
    .clk(clk), .rst(rst), .load(load_rd_c), .load_payload({cmd_addr, cmd_prot}),
    .ready(m_arready), .valid(m_arvalid), .payload(ar_payload), .hs_c(ar_hs_c)
  );

  assign {m_awaddr, m_awprot} = aw_payload;
  assign {m_wdata, m_wstrb}   = w_payload;
  assign {m_araddr, m_arprot} = ar_payload;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cmd_ready <= 1'b0;
      m_bready  <= 1'b0;
      m_rready  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_ready <= cmd_ready_d;
      m_bready  <= bready_d;
      m_rready  <= rready_d;
      rsp_valid <= rsp_valid_d;
      rsp_write <= rsp_write_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_resp  <= rsp_resp_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Next state plus next values of the registered handshake/response outputs.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = 1'b0;
    bready_d    = 1'b0;
    rready_d    = 1'b0;
    rsp_valid_d = rsp_valid;
    rsp_write_d = rsp_write;
    rsp_rdata_d = rsp_rdata;
    rsp_resp_d  = rsp_resp;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d   = cmd_write ? ST_WR_REQ : ST_RD_REQ;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      ST_WR_REQ: begin
        aw_done_d = aw_done_q | aw_hs_c;
        w_done_d  = w_done_q | w_hs_c;
        if (aw_done_d && w_done_d) begin
          state_d  = ST_WR_RESP;
          bready_d = 1'b1;
        end
      end
      ST_WR_RESP: begin
        if (m_bvalid && m_bready) begin
          state_d     = ST_RSP;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = 2'(axi4_lite_map_resp(m_bresp));
        end else begin
          bready_d = 1'b1;
        end
      end
      ST_RD_REQ: begin
        if (ar_hs_c) begin
          state_d  = ST_RD_DATA;
          rready_d = 1'b1;
        end
      end
      ST_RD_DATA: begin
        if (m_rvalid && m_rready) begin
          state_d     = ST_RSP;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = m_rdata;
          rsp_resp_d  = 2'(axi4_lite_map_resp(m_rresp));
        end else begin
          rready_d = 1'b1;
        end
      end
      ST_RSP: begin
        if (rsp_valid && rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_amba_axi4_lite_master.sv
// Directed bench for amba_axi4_lite_master: a vector table of single
// transactions against a scripted slave, plus reset sequences.
module tb_amba_axi4_lite_master;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_wstrb;
  logic [2:0]        cmd_prot;
  logic              rsp_valid, rsp_ready, rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_resp;
  logic              m_awvalid, m_awready;
  logic [ADDR_W-1:0] m_awaddr;
  logic [2:0]        m_awprot;
  logic              m_wvalid, m_wready;
  logic [DATA_W-1:0] m_wdata;
  logic [STRB_W-1:0] m_wstrb;
  logic              m_bvalid, m_bready;
  logic [1:0]        m_bresp;
  logic              m_arvalid, m_arready;
  logic [ADDR_W-1:0] m_araddr;
  logic [2:0]        m_arprot;
  logic              m_rvalid, m_rready;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0]        m_rresp;

  always #5 clk = ~clk;

  amba_axi4_lite_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          aw_dly, w_dly, ar_dly, hold;
    logic [1:0]  sresp;
    logic [31:0] srdata;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    int          exp_lat, exp_aw, exp_w, exp_ar;
  } vec_t;

  localparam int NVEC = 9;
  vec_t vecs[NVEC];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One command through the DUT with a scripted slave; checks latency,
  // per-channel valid durations, payload stability and the response.
  task automatic run_txn(input vec_t v, input string tag);
    int t, cyc, lat, aw_c, w_c, ar_c, b_hs;
    bit aw_done, w_done, ar_done, b_sent, r_sent, stable;
    bit aw_fire, w_fire, ar_fire, b_clr, r_clr;
    logic [31:0] cap_rdata;
    logic [1:0]  cap_resp;
    logic        cap_write;
    t = 0; lat = -1; aw_c = 0; w_c = 0; ar_c = 0; b_hs = 0;
    aw_done = 0; w_done = 0; ar_done = 0; b_sent = 0; r_sent = 0; stable = 1;
    cap_rdata = '0; cap_resp = '0; cap_write = 1'b0;
    while (!cmd_ready && t < 20) begin
      tick();
      t++;
    end
    check({tag, " cmd_ready_wait"}, 64'(t), 64'(0));
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_wstrb = v.strb; cmd_prot = v.prot;
    tick();
    cmd_valid = 1'b0;
    cyc = 1;
    while (cyc < 60 && lat < 0) begin
      if (rsp_valid) begin
        lat = cyc; cap_rdata = rsp_rdata; cap_resp = rsp_resp; cap_write = rsp_write;
      end else begin
        aw_fire = 0; w_fire = 0; ar_fire = 0;
        if (m_awvalid) begin
          aw_c++;
          if (m_awaddr !== v.addr || m_awprot !== v.prot) stable = 0;
          m_awready = (aw_c > v.aw_dly);
          aw_fire = m_awready;
        end else m_awready = 1'b0;
        if (m_wvalid) begin
          w_c++;
          if (m_wdata !== v.wdata || m_wstrb !== v.strb) stable = 0;
          m_wready = (w_c > v.w_dly);
          w_fire = m_wready;
        end else m_wready = 1'b0;
        if (m_arvalid) begin
          ar_c++;
          if (m_araddr !== v.addr || m_arprot !== v.prot) stable = 0;
          m_arready = (ar_c > v.ar_dly);
          ar_fire = m_arready;
        end else m_arready = 1'b0;
        if (aw_done && w_done && !b_sent) begin
          m_bvalid = 1'b1; m_bresp = v.sresp;
        end
        b_clr = m_bvalid && m_bready;
        if (b_clr) b_hs++;
        if (ar_done && !r_sent) begin
          m_rvalid = 1'b1; m_rdata = v.srdata; m_rresp = v.sresp;
        end
        r_clr = m_rvalid && m_rready;
        tick();
        cyc++;
        if (aw_fire) aw_done = 1;
        if (w_fire) w_done = 1;
        if (ar_fire) ar_done = 1;
        if (b_clr) begin m_bvalid = 1'b0; b_sent = 1; end
        if (r_clr) begin m_rvalid = 1'b0; r_sent = 1; end
      end
    end
    m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
    check({tag, " latency"}, 64'(lat), 64'(v.exp_lat));
    check({tag, " rsp_write"}, 64'(cap_write), 64'(v.wr));
    check({tag, " rsp_rdata"}, 64'(cap_rdata), 64'(v.exp_rdata));
    check({tag, " rsp_resp"}, 64'(cap_resp), 64'(v.exp_resp));
    check({tag, " awvalid_cycles"}, 64'(aw_c), 64'(v.exp_aw));
    check({tag, " wvalid_cycles"}, 64'(w_c), 64'(v.exp_w));
    check({tag, " arvalid_cycles"}, 64'(ar_c), 64'(v.exp_ar));
    check({tag, " b_handshakes"}, 64'(b_hs), 64'(v.wr ? 1 : 0));
    check({tag, " payload_stable"}, 64'(stable), 64'(1));
    for (int h = 0; h < v.hold; h++) begin
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'hFFFF_FFF0;
      rsp_ready = 1'b0;
      check($sformatf("%s hold%0d cmd_ready", tag, h), 64'(cmd_ready), 64'(0));
      check($sformatf("%s hold%0d rsp_valid", tag, h), 64'(rsp_valid), 64'(1));
      check($sformatf("%s hold%0d rsp_rdata", tag, h), 64'(rsp_rdata), 64'(cap_rdata));
      check($sformatf("%s hold%0d rsp_resp", tag, h), 64'(rsp_resp), 64'(cap_resp));
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, " rsp_valid_drop"}, 64'(rsp_valid), 64'(0));
    check({tag, " cmd_ready_after"}, 64'(cmd_ready), 64'(1));
  endtask

  function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input logic [2:0] prot,
                              input int aw_dly, input int w_dly, input int ar_dly, input int hold,
                              input logic [1:0] sresp, input logic [31:0] srdata,
                              input logic [1:0] exp_resp, input logic [31:0] exp_rdata,
                              input int exp_lat, input int exp_aw, input int exp_w, input int exp_ar);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb; v.prot = prot;
    v.aw_dly = aw_dly; v.w_dly = w_dly; v.ar_dly = ar_dly; v.hold = hold;
    v.sresp = sresp; v.srdata = srdata; v.exp_resp = exp_resp; v.exp_rdata = exp_rdata;
    v.exp_lat = exp_lat; v.exp_aw = exp_aw; v.exp_w = exp_w; v.exp_ar = exp_ar;
    return v;
  endfunction

  initial begin
    vec_t rv;
    //            wr  addr          wdata         strb  prot    aw w ar hold sresp  srdata        exp_resp exp_rdata     lat aw w ar
    vecs[0] = mk(1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 3'b000, 0, 0, 0, 0, 2'b00, 32'h0,         2'b00, 32'h0,         3, 1, 1, 0);
    vecs[1] = mk(1, 32'h0000_0010, 32'h1234_5678, 4'h3, 3'b010, 0, 5, 0, 0, 2'b00, 32'h0,         2'b00, 32'h0,         8, 1, 6, 0);
    vecs[2] = mk(0, 32'h0000_0008, 32'h0,         4'h0, 3'b001, 0, 0, 2, 0, 2'b00, 32'h0000_0007, 2'b00, 32'h0000_0007, 5, 0, 0, 3);
    vecs[3] = mk(1, 32'h0000_0020, 32'h0000_00FF, 4'h1, 3'b000, 0, 0, 0, 0, 2'b01, 32'h0,         2'b10, 32'h0,         3, 1, 1, 0);
    vecs[4] = mk(0, 32'h0000_0030, 32'h0,         4'h0, 3'b100, 0, 0, 0, 0, 2'b11, 32'hCAFE_F00D, 2'b11, 32'hCAFE_F00D, 3, 0, 0, 1);
    vecs[5] = mk(1, 32'h0000_0044, 32'hA5A5_A5A5, 4'hC, 3'b111, 3, 0, 0, 0, 2'b10, 32'h0,         2'b10, 32'h0,         6, 4, 1, 0);
    vecs[6] = mk(0, 32'h0000_0100, 32'h0,         4'h0, 3'b000, 0, 0, 0, 4, 2'b00, 32'h0000_55AA, 2'b00, 32'h0000_55AA, 3, 0, 0, 1);
    vecs[7] = mk(0, 32'h0000_0104, 32'h0,         4'h0, 3'b010, 0, 0, 0, 0, 2'b01, 32'h0000_1234, 2'b10, 32'h0000_1234, 3, 0, 0, 1);
    vecs[8] = mk(1, 32'h0000_0200, 32'h0F0F_0F0F, 4'hF, 3'b001, 2, 2, 0, 2, 2'b11, 32'h0,         2'b11, 32'h0,         5, 3, 3, 0);

    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; cmd_prot = '0; rsp_ready = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = '0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;

    // Reset values
    repeat (3) tick();
    check("reset cmd_ready", 64'(cmd_ready), 64'(0));
    check("reset valids", 64'({m_awvalid, m_wvalid, m_arvalid, rsp_valid}), 64'(0));
    check("reset readies", 64'({m_bready, m_rready}), 64'(0));
    check("reset rsp_rdata", 64'(rsp_rdata), 64'(0));
    check("reset rsp_resp", 64'(rsp_resp), 64'(0));
    check("reset awaddr", 64'(m_awaddr), 64'(0));
    rst = 1'b0;
    tick();
    check("post-reset cmd_ready", 64'(cmd_ready), 64'(1));

    for (int i = 0; i < NVEC; i++) run_txn(vecs[i], $sformatf("v%0d", i));

    // Reset while waiting for B: everything drops and no response appears
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0080;
    cmd_wdata = 32'h1111_2222; cmd_wstrb = 4'hF; cmd_prot = 3'b000;
    check("midrst cmd_ready", 64'(cmd_ready), 64'(1));
    tick();
    cmd_valid = 1'b0;
    check("midrst aw_w_valid", 64'({m_awvalid, m_wvalid}), 64'(2'b11));
    m_awready = 1'b1; m_wready = 1'b1;
    tick();
    m_awready = 1'b0; m_wready = 1'b0;
    check("midrst bready", 64'(m_bready), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst valids", 64'({m_awvalid, m_wvalid, m_arvalid, rsp_valid}), 64'(0));
    check("midrst readies", 64'({m_bready, m_rready, cmd_ready}), 64'(0));
    tick();
    check("midrst no rsp", 64'(rsp_valid), 64'(0));
    check("midrst cmd_ready back", 64'(cmd_ready), 64'(1));

    rv = mk(0, 32'h0000_000C, 32'h0, 4'h0, 3'b000, 0, 0, 0, 0, 2'b00, 32'hBEEF_0001,
            2'b00, 32'hBEEF_0001, 3, 0, 0, 1);
    run_txn(rv, "after_reset_read");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/amba_axi4_lite_master.md
Name: amba_axi4_lite_master

Overview:
- AXI4-Lite initiator (manager) that drives the slave side of the AMBA adder block and any other AXI4-Lite responder.
- Accepts one single-beat read or write command on a simple valid/ready command port and runs the full AXI4-Lite channel handshakes.
- Returns data and response on a valid/ready response port.
- One transaction in flight at a time. Used by testbench drivers and by on-chip control logic.

Parameters:
ADDR_W, 32, address width on cmd_addr, AWADDR and ARADDR.
DATA_W, 32, data width; must be 32 or 64; STRB_W = DATA_W/8.

Ports:
clk  in  1  system clock; all logic rising-edge.
rst  in  1  synchronous, active-high reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  master can accept a command.
cmd_write  in  1  1 = write, 0 = read.
cmd_addr  in  ADDR_W  byte address.
cmd_wdata  in  DATA_W  write data (ignored on read).
cmd_wstrb  in  STRB_W  byte strobes (ignored on read).
cmd_prot  in  3  axi4_prot_typel {instruction, non_secure, privileged}.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts response.
rsp_write  out  1  response belongs to a write.
rsp_rdata  out  DATA_W  read data; 0 for writes.
rsp_resp  out  2  axi4_resp_el.
m_awvalid, m_awready, m_awaddr[ADDR_W], m_awprot[3]  AW channel, standard AXI4-Lite directions.
m_wvalid, m_wready, m_wdata[DATA_W], m_wstrb[STRB_W]  W channel.
m_bvalid, m_bready, m_bresp[2]  B channel.
m_arvalid, m_arready, m_araddr[ADDR_W], m_arprot[3]  AR channel.
m_rvalid, m_rready, m_rdata[DATA_W], m_rresp[2]  R channel.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - state IDLE.
  - cmd_ready=0 while rst=1.
  - All m_*valid, m_bready, m_rready and rsp_valid = 0.
  - Address, data and response registers 0.
- Reset mid-transaction: abandon immediately, drop all valids next edge, emit no response.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, register all cmd fields.
  - Go to WR_REQ (write) or RD_REQ (read); the matching valids assert on the next cycle (1-cycle issue latency).
- WR_REQ:
  - m_awvalid and m_wvalid assert together.
  - Each drops independently on the cycle after its own handshake (valid&ready); AW and W may complete in either order or the same cycle.
  - When both have completed, go to WR_RESP.
  - Payloads stay stable while the corresponding valid is high.
- WR_RESP:
  - m_bready=1.
  - On m_bvalid, capture m_bresp; rsp_write=1; rsp_rdata=0; go to RSP.
- RD_REQ:
  - m_arvalid=1 until m_arready, then go to RD_DATA.
- RD_DATA:
  - m_rready=1.
  - On m_rvalid, capture m_rdata and m_rresp; rsp_write=0; go to RSP.
- Response mapping: EXOKAY (2'b01) from the slave is reported as SLVERR (2'b10) on rsp_resp, since exclusive access is not supported on AXI4-Lite. OKAY, SLVERR and DECERR pass unchanged.
- RSP:
  - rsp_valid=1, held stable until rsp_ready.
  - On that handshake, return to IDLE; cmd_ready rises the following cycle.
- Minimum transaction length (ready slave and consumer):
  - write: cmd accept → response valid = 3 cycles.
  - read: 3 cycles.
  - back-to-back command spacing: 4 cycles.
- No valid is ever deasserted before its handshake, and no valid depends combinationally on a ready.
- m_awprot and m_arprot carry the registered cmd_prot.
- Read data is passed unmodified, even on an error response.

Decomposition:
- amba_axi4_lite_types_pkg:
  - existing axi4_resp_el and axi4_prot_typel.
  - add state enum axi4_lite_mst_state_e.
  - add a function that maps EXOKAY to SLVERR.
- Optional sub-module amba_axi4_lite_hold_ch: a one-channel valid/payload holder, instanced for AW, W and AR.

Test Plan:
1. Write addr 0x0000_0004, data 0xDEAD_BEEF, strb 0xF; awready and wready=1 the same cycle; bresp OKAY → AW/W valid exactly one cycle; rsp_valid 3 cycles after accept; rsp_write=1; rsp_resp=OKAY.
2. Write with wready delayed 5 cycles after awready → awvalid drops after 1 cycle; wvalid held 6 cycles with stable wdata; exactly one B handshake.
3. Read addr 0x8; arready delayed 2 cycles; rdata 0x0000_0007, rresp OKAY → rsp_rdata=0x7; rsp_write=0; araddr stable throughout.
4. Slave returns bresp EXOKAY → rsp_resp=SLVERR. Read with rresp DECERR → rsp_resp=DECERR and rdata passed through.
5. Hold rsp_ready=0 for 4 cycles with a new cmd_valid pending → cmd_ready stays 0 and the rsp fields stay stable; new command accepted 1 cycle after the response handshake.
6. Assert rst during WR_RESP (bvalid never arrives) → next cycle all valids and readies are 0; no rsp_valid; a new read afterwards completes normally.
